// File: rtl/sharp_fb_writer.sv
// sharp_fb_writer: moves one received SPI scanline (spi_ck domain) into the
// panel framebuffer RAM as WPL words of WORDW bits, on the system clock.
//
// Handshake: sl_write is a level strobe from a slower clock domain. It is
// synchronised, and its rising edge starts one operation. There is no
// back-pressure. fb_we writes one word on every cycle it is high. busy is
// high for the whole operation. line_done, bad_line and overrun are each
// single-cycle pulses.
//
// Optional feature macro: FB_CLEAR_ALL_EN (cmd[2] clears the whole frame
// to white).
module sharp_fb_writer #(
  parameter int WIDTH = 144,
  parameter int LINES = 168,
  parameter int WORDW = 16,
  parameter int WPL   = 9,
  parameter int AW    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH+15:0] scanline,
  input  logic              sl_write,
  output logic              fb_we,
  output logic [AW-1:0]     fb_addr,
  output logic [WORDW-1:0]  fb_wdata,
  output logic              busy,
  output logic              line_done,
  output logic              bad_line,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int KW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [AW-1:0] WPL_AW    = AW'(WPL);
  localparam logic [KW-1:0] LAST_K    = KW'(WPL - 1);
`ifdef FB_CLEAR_ALL_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(LINES * WPL - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1
`ifdef FB_CLEAR_ALL_EN
    , S_CLEAR = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [KW-1:0]      k_q, k_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WORDW-1:0]   wdata_q, wdata_d;
  logic               line_done_q, line_done_d;
  logic               bad_line_q, bad_line_d;
  logic               overrun_q, overrun_d;

  logic               strobe_edge;
  logic [7:0]         cmd;
  logic [7:0]         line_num;
  logic               line_ok;
  logic [AW-1:0]      line_m1;
  logic [AW-1:0]      base_addr;
  logic               unused_cmd;

  // cmd[1] (VCOM) never affects the framebuffer; cmd[2] only matters with clear enabled.
  assign unused_cmd = ^cmd[7:1];

  // Two-flop synchroniser plus an edge-detect flop for the spi_ck strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sl_write;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Decode the incoming line header; the base address stays within AW bits for legal lines.
  always_comb begin
    strobe_edge = sync2_q & ~sync3_q;
    cmd         = scanline[7:0];
    line_num    = scanline[15:8];
    line_ok     = (line_num != 8'd0) && (32'(line_num) <= 32'(LINES));
    line_m1     = AW'(line_num) - AW'(1);
    base_addr   = line_m1 * WPL_AW;
  end

  // Next-state logic: word 0 comes straight from the bus, later words from the hold register.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    k_d         = k_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    line_done_d = 1'b0;
    bad_line_d  = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe_edge) begin
          hold_d = scanline[WIDTH+15:16];
`ifdef FB_CLEAR_ALL_EN
          if (cmd[2]) begin
            state_d = S_CLEAR;
            addr_d  = '0;
            wdata_d = '1;
          end else
`endif
          if (cmd[0]) begin
            if (!line_ok) begin
              bad_line_d = 1'b1;
            end else begin
              state_d = S_WRITE;
              k_d     = '0;
              addr_d  = base_addr;
              wdata_d = scanline[16 +: WORDW];
            end
          end
        end
      end
      S_WRITE: begin
        overrun_d = strobe_edge;
        if (k_q == LAST_K) begin
          state_d     = S_IDLE;
          line_done_d = 1'b1;
        end else begin
          k_d     = k_q + KW'(1);
          addr_d  = addr_q + AW'(1);
          wdata_d = hold_q[int'(k_d) * WORDW +: WORDW];
        end
      end
`ifdef FB_CLEAR_ALL_EN
      S_CLEAR: begin
        overrun_d = strobe_edge;
        if (addr_q == LAST_ADDR) begin
          state_d     = S_IDLE;
          line_done_d = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      line_done_q <= 1'b0;
      bad_line_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      line_done_q <= line_done_d;
      bad_line_q  <= bad_line_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef FB_CLEAR_ALL_EN
  assign fb_we = (state_q == S_WRITE) || (state_q == S_CLEAR);
`else
  assign fb_we = (state_q == S_WRITE);
`endif
  assign busy      = (state_q != S_IDLE);
  assign fb_addr   = addr_q;
  assign fb_wdata  = wdata_q;
  assign line_done = line_done_q;
  assign bad_line  = bad_line_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sharp_fb_writer.sv
// Bench for sharp_fb_writer: directed cases plus random lines, with a
// reference model that turns a scanline into the list of expected RAM writes.
module tb_sharp_fb_writer;

  localparam int LINES = 168;
  localparam int WPL   = 9;
  localparam int AW    = 11;
  localparam int WORDW = 16;
  localparam int EW    = AW + WORDW;

  logic              clk = 1'b0;
  logic              rst;
  logic [159:0]      scanline;
  logic              sl_write;
  logic              fb_we;
  logic [AW-1:0]     fb_addr;
  logic [WORDW-1:0]  fb_wdata;
  logic              busy, line_done, bad_line, overrun;
  logic [1:0]        dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int exp_done = 0, exp_bad = 0, exp_ovr = 0;
  int seen_done = 0, seen_bad = 0, seen_ovr = 0;
  logic prev_we = 1'b0;

  sharp_fb_writer dut (
    .clk(clk), .rst(rst), .scanline(scanline), .sl_write(sl_write),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .busy(busy),
    .line_done(line_done), .bad_line(bad_line), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: what the framebuffer must see for one accepted strobe
  task automatic expect_line(input logic [159:0] sl);
    logic [7:0]  cmd;
    int          line;
    int          a;
    logic [15:0] d;
    cmd  = sl[7:0];
    line = int'(sl[15:8]);
`ifdef FB_CLEAR_ALL_EN
    if (cmd[2]) begin
      for (int n = 0; n < LINES * WPL; n++) exp_q.push_back({AW'(n), 16'hFFFF});
      exp_done++;
      return;
    end
`endif
    if (!cmd[0]) return;
    if (line < 1 || line > LINES) begin
      exp_bad++;
      return;
    end
    for (int k = 0; k < WPL; k++) begin
      a = (line - 1) * WPL + k;
      for (int i = 0; i < 16; i++) d[i] = sl[16 + 16 * k + i];
      exp_q.push_back({AW'(a), d});
    end
    exp_done++;
  endtask

  function automatic logic [159:0] make_sl(input logic [7:0] cmd, input logic [7:0] line);
    logic [159:0] s;
    for (int j = 0; j < 5; j++) s[32 * j +: 32] = $urandom();
    s[7:0]  = cmd;
    s[15:8] = line;
    return s;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {fb_addr, fb_wdata}, '0);
          n_fail += (fb_addr == '0 && fb_wdata == '0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 64'(fb_addr), 64'(e[EW-1:WORDW]));
          chk("write_data", 64'(fb_wdata), 64'(e[WORDW-1:0]));
        end
      end
      if (line_done) begin
        seen_done++;
        chk("line_done_timing_we_busy", {prev_we, busy, fb_we}, 3'b100);
      end
      if (bad_line) seen_bad++;
      if (overrun) seen_ovr++;
      prev_we = fb_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // drivers
  task automatic strobe(input logic [159:0] sl);
    @(negedge clk);
    scanline = sl;
    sl_write = 1'b1;
    repeat (3) @(negedge clk);
    sl_write = 1'b0;
  endtask

  task automatic strobe_pair(input logic [159:0] a, input logic [159:0] b, input int d);
    @(negedge clk);
    scanline = a;
    sl_write = 1'b1;
    repeat (3) @(negedge clk);
    sl_write = 1'b0;
    repeat (d - 3) @(negedge clk);
    scanline = b;
    sl_write = 1'b1;
    repeat (3) @(negedge clk);
    sl_write = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cnt;
    repeat (5) @(negedge clk);
    cnt = 0;
    while ((busy || exp_q.size() != 0) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_idle_pending"}, {busy, exp_q.size() != 0}, 2'b00);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk({name, "_line_done_cnt"}, seen_done, exp_done);
    chk({name, "_bad_line_cnt"}, seen_bad, exp_bad);
    chk({name, "_overrun_cnt"}, seen_ovr, exp_ovr);
  endtask

  // stimulus
  initial begin
    logic [159:0] sa, sb;
    logic [7:0]   cmd, line;
    int           r;
    bit           found;
    rst = 1'b1;
    scanline = '0;
    sl_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {line_done, bad_line, overrun}, 0);
    chk("rst_addr_data", {fb_addr, fb_wdata}, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // line 1, first word A5A5
    sa = make_sl(8'h01, 8'd1);
    sa[31:16] = 16'hA5A5;
    expect_line(sa);
    strobe(sa);
    wait_idle("t1_line1", 60);

    // last legal line with all-white pixels, then one past the end
    sa = '1;
    sa[7:0] = 8'h01;
    sa[15:8] = 8'd168;
    expect_line(sa);
    strobe(sa);
    wait_idle("t2_line168", 60);
    sa = make_sl(8'h01, 8'd169);
    expect_line(sa);
    strobe(sa);
    wait_idle("t2_line169", 60);

    // line 0 rejected, then line 5
    sa = make_sl(8'h01, 8'd0);
    expect_line(sa);
    strobe(sa);
    wait_idle("t3_line0", 60);
    sa = make_sl(8'h01, 8'd5);
    expect_line(sa);
    strobe(sa);
    wait_idle("t3_line5", 60);

    // M0 clear: silent drop
    sa = make_sl(8'h00, 8'd7);
    expect_line(sa);
    strobe(sa);
    wait_idle("m0_drop", 60);

    // overrun: second edge 4 clk after the first
    sa = make_sl(8'h01, 8'd10);
    sb = make_sl(8'h01, 8'd20);
    expect_line(sa);
    exp_ovr++;
    strobe_pair(sa, sb, 4);
    wait_idle("t4_overrun_d4", 80);

    // overrun: edge lands on the last write cycle
    sa = make_sl(8'h01, 8'd30);
    sb = make_sl(8'h01, 8'd31);
    expect_line(sa);
    exp_ovr++;
    strobe_pair(sa, sb, 9);
    wait_idle("overrun_d9", 80);

    // back-to-back: edge on the cycle busy falls is accepted
    sa = make_sl(8'h01, 8'd40);
    sb = make_sl(8'h01, 8'd41);
    expect_line(sa);
    expect_line(sb);
    strobe_pair(sa, sb, 10);
    wait_idle("back_to_back_d10", 80);

    // reset at the 3rd write of line 2
    sa = make_sl(8'h01, 8'd2);
    expect_line(sa);
    strobe(sa);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (fb_we && fb_addr == AW'(WPL + 2)) found = 1'b1;
      else @(negedge clk);
    end
    chk("t5_third_write_seen", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_fb_we", fb_we, 0);
    chk("t5_rst_busy", busy, 0);
    exp_q.delete();
    exp_done = seen_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_post_rst_quiet", {fb_we, busy}, 2'b00);
    wait_idle("t5_reset", 20);

`ifdef FB_CLEAR_ALL_EN
    sa = make_sl(8'h04, 8'd0);
    expect_line(sa);
    strobe(sa);
    wait_idle("t6_clear_all", 2000);
`else
    sa = make_sl(8'h05, 8'd3);
    expect_line(sa);
    strobe(sa);
    wait_idle("t6_cmd05_line3", 60);
`endif

    // random lines
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      cmd = 8'($urandom());
      cmd[0] = 1'b1;
`ifdef FB_CLEAR_ALL_EN
      cmd[2] = 1'b0;
`endif
      line = 8'($urandom_range(1, LINES));
      if (r == 0) line = 8'd0;
      if (r == 1) line = 8'($urandom_range(LINES + 1, 255));
      if (r == 2) cmd[0] = 1'b0;
      sa = make_sl(cmd, line);
      expect_line(sa);
      strobe(sa);
      wait_idle("random", 60);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
